// File: rtl/pass_arbiter.sv
// Round-robin arbiter sharing one fixed-latency datapath between two requesters;
// results come back tagged with the requester ID that issued them.
module pass_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DUT_LAT    = 1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  req0_valid,
  input  logic [DATA_WIDTH-1:0] req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [DATA_WIDTH-1:0] req1_data,
  output logic                  req1_ready,
  output logic [DATA_WIDTH-1:0] dut_data_i,
  input  logic [DATA_WIDTH-1:0] dut_data_o,
  input  logic                  dut_bool_o,
  output logic                  resp_valid,
  output logic                  resp_id,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_bool,
  output logic [CNT_WIDTH-1:0]  grant_cnt0,
  output logic [CNT_WIDTH-1:0]  grant_cnt1
);

  // ptr_q = 1 gives requester 1 priority when both are valid
  logic               ptr_q;
  logic               gnt0;
  logic               gnt1;
  logic               accept;
  logic [DUT_LAT-1:0] tag_vld_q;
  logic [DUT_LAT-1:0] tag_id_q;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (en && !rst) begin
      if (req0_valid && req1_valid) begin
        gnt0 = ~ptr_q;
        gnt1 = ptr_q;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign accept     = gnt0 | gnt1;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= 1'b0;
      dut_data_i <= '0;
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (accept) begin
      ptr_q      <= gnt0;
      dut_data_i <= gnt1 ? req1_data : req0_data;
      if (gnt0 && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + CNT_WIDTH'(1);
      if (gnt1 && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + CNT_WIDTH'(1);
    end
  end

  // Tag shift register runs every cycle so in-flight items drain even with en low
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q <= '0;
      tag_id_q  <= '0;
    end else begin
      tag_vld_q <= (tag_vld_q << 1) | DUT_LAT'(accept);
      tag_id_q  <= (tag_id_q << 1) | DUT_LAT'(gnt1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_data  <= '0;
      resp_bool  <= 1'b0;
    end else if (tag_vld_q[DUT_LAT-1]) begin
      resp_valid <= 1'b1;
      resp_id    <= tag_id_q[DUT_LAT-1];
      resp_data  <= dut_data_o;
      resp_bool  <= dut_bool_o;
    end else begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pass_arbiter.sv
// Scoreboard bench: instance A (DUT_LAT=1, 16-bit counters) and instance B
// (DUT_LAT=4, 4-bit counters) share one stimulus stream and one grant model.
module tb_pass_arbiter;

  typedef struct packed {
    int unsigned due;
    logic        id;
    logic [7:0]  data;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       v0 = 1'b0;
  logic       v1 = 1'b0;
  logic [7:0] d0 = '0;
  logic [7:0] d1 = '0;

  logic        r0_a, r1_a, rv_a, rid_a, rb_a;
  logic [7:0]  din_a, dout_a, rd_a;
  logic [15:0] c0_a, c1_a;
  logic        r0_b, r1_b, rv_b, rid_b, rb_b;
  logic [7:0]  din_b, dout_b, rd_b;
  logic [3:0]  c0_b, c1_b;
  logic [7:0]  dly_b [3];

  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          resp_seen [2];
  exp_t        sb_q [2][$];

  // Grant/counter reference model (state as it will be after the next edge)
  logic        ptr_m = 1'b0;
  logic [15:0] c0_m16 = '0, c1_m16 = '0;
  logic [3:0]  c0_m4 = '0, c1_m4 = '0;
  logic [7:0]  last_m = '0;
  logic        armed = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath stand-ins: A sees its input within the same cycle, B through 3 registers
  assign dout_a = din_a;
  always @(posedge clk) begin
    dly_b[0] <= din_b;
    dly_b[1] <= dly_b[0];
    dly_b[2] <= dly_b[1];
  end
  assign dout_b = dly_b[2];

  pass_arbiter #(.DATA_WIDTH(8), .DUT_LAT(1), .CNT_WIDTH(16)) u_dut_a (
    .clk(clk), .rst(rst), .en(en),
    .req0_valid(v0), .req0_data(d0), .req0_ready(r0_a),
    .req1_valid(v1), .req1_data(d1), .req1_ready(r1_a),
    .dut_data_i(din_a), .dut_data_o(dout_a), .dut_bool_o(^dout_a),
    .resp_valid(rv_a), .resp_id(rid_a), .resp_data(rd_a), .resp_bool(rb_a),
    .grant_cnt0(c0_a), .grant_cnt1(c1_a)
  );

  pass_arbiter #(.DATA_WIDTH(8), .DUT_LAT(4), .CNT_WIDTH(4)) u_dut_b (
    .clk(clk), .rst(rst), .en(en),
    .req0_valid(v0), .req0_data(d0), .req0_ready(r0_b),
    .req1_valid(v1), .req1_data(d1), .req1_ready(r1_b),
    .dut_data_i(din_b), .dut_data_o(dout_b), .dut_bool_o(^dout_b),
    .resp_valid(rv_b), .resp_id(rid_b), .resp_data(rd_b), .resp_bool(rb_b),
    .grant_cnt0(c0_b), .grant_cnt1(c1_b)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    v0  = 1'b0;
    v1  = 1'b0;
    step(1);
    rst = 1'b0;
  endtask

  // Monitor: pops expected responses, checks ready/counters against the model
  initial begin
    logic       g0, g1, rv, rid, rb;
    logic [7:0] rd;
    exp_t       e;
    resp_seen[0] = 0;
    resp_seen[1] = 0;
    forever begin
      @(negedge clk);
      if (armed) begin
        for (int k = 0; k < 2; k++) begin
          rv  = (k == 0) ? rv_a : rv_b;
          rid = (k == 0) ? rid_a : rid_b;
          rd  = (k == 0) ? rd_a : rd_b;
          rb  = (k == 0) ? rb_a : rb_b;
          if (rv) resp_seen[k]++;
          if (rv && sb_q[k].size() == 0) begin
            check_val("resp_unexpected", 32'(rv), 32'd0);
          end else if (rv) begin
            e = sb_q[k].pop_front();
            check_val("resp_cycle", cyc, e.due);
            check_val("resp_id", 32'(rid), 32'(e.id));
            check_val("resp_data", 32'(rd), 32'(e.data));
            check_val("resp_bool", 32'(rb), 32'(^e.data));
          end else if (sb_q[k].size() > 0 && sb_q[k][0].due <= cyc) begin
            check_val("resp_missing", 32'(rv), 32'd1);
            void'(sb_q[k].pop_front());
          end
        end
      end
      g0 = en && !rst && v0 && (!v1 || !ptr_m);
      g1 = en && !rst && v1 && (!v0 || ptr_m);
      if (armed) begin
        check_val("ready0_a", 32'(r0_a), 32'(g0));
        check_val("ready1_a", 32'(r1_a), 32'(g1));
        check_val("ready0_b", 32'(r0_b), 32'(g0));
        check_val("ready1_b", 32'(r1_b), 32'(g1));
        check_val("cnt0_a", 32'(c0_a), 32'(c0_m16));
        check_val("cnt1_a", 32'(c1_a), 32'(c1_m16));
        check_val("cnt0_b", 32'(c0_b), 32'(c0_m4));
        check_val("cnt1_b", 32'(c1_b), 32'(c1_m4));
        check_val("dut_in_a", 32'(din_a), 32'(last_m));
      end
      if (rst) begin
        // anything still queued would be captured at or after the reset edge
        sb_q[0].delete();
        sb_q[1].delete();
        ptr_m  = 1'b0;
        c0_m16 = '0;
        c1_m16 = '0;
        c0_m4  = '0;
        c1_m4  = '0;
        last_m = '0;
        armed  = 1'b1;
      end else if (g0 || g1) begin
        e.id   = g1;
        e.data = g1 ? d1 : d0;
        e.due  = cyc + 2;
        sb_q[0].push_back(e);
        e.due  = cyc + 5;
        sb_q[1].push_back(e);
        ptr_m  = g0;
        last_m = e.data;
        if (g0 && c0_m16 != 16'hFFFF) c0_m16 = c0_m16 + 16'd1;
        if (g1 && c1_m16 != 16'hFFFF) c1_m16 = c1_m16 + 16'd1;
        if (g0 && c0_m4 != 4'hF) c0_m4 = c0_m4 + 4'd1;
        if (g1 && c1_m4 != 4'hF) c1_m4 = c1_m4 + 4'd1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int snap;
    // Reset held with both requesters valid
    rst = 1'b1;
    v0  = 1'b1;
    v1  = 1'b1;
    d0  = 8'h55;
    d1  = 8'h66;
    step(1);
    check_val("rst_ready0", 32'(r0_a), 32'd0);
    check_val("rst_ready1", 32'(r1_a), 32'd0);
    step(2);
    rst = 1'b0;
    #1;
    check_val("post_rst_resp_valid", 32'(rv_a), 32'd0);
    check_val("post_rst_resp_data", 32'(rd_b), 32'd0);
    check_val("post_rst_dut_in", 32'(din_b), 32'd0);
    check_val("first_grant0", 32'(r0_a), 32'd1);
    check_val("first_grant1", 32'(r1_a), 32'd0);
    step(1);
    v0 = 1'b0;
    v1 = 1'b0;
    step(6);

    // Single requester, back-to-back
    do_reset();
    v0 = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      d0 = 8'(i);
      step(1);
    end
    v0 = 1'b0;
    step(6);
    check_val("single_cnt0", 32'(c0_a), 32'd3);

    // Contention: strict alternation
    do_reset();
    v0 = 1'b1;
    v1 = 1'b1;
    d0 = 8'hA0;
    d1 = 8'hB0;
    step(8);
    v0 = 1'b0;
    v1 = 1'b0;
    step(6);
    check_val("cont_cnt0", 32'(c0_a), 32'd4);
    check_val("cont_cnt1", 32'(c1_a), 32'd4);

    // Enable gap mid-stream; grants 0,1,0 then requester 1 must win on resume
    do_reset();
    v0 = 1'b1;
    v1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d0 = 8'h10 + 8'(i);
      d1 = 8'h20 + 8'(i);
      step(1);
    end
    en = 1'b0;
    step(4);
    en = 1'b1;
    #1;
    check_val("resume_grant1", 32'(r1_b), 32'd1);
    check_val("resume_grant0", 32'(r0_b), 32'd0);
    step(2);
    v0 = 1'b0;
    v1 = 1'b0;
    step(6);

    // Reset while items are in flight
    do_reset();
    v0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d0 = 8'h31 + 8'(i);
      step(1);
    end
    v0   = 1'b0;
    snap = resp_seen[1];
    rst  = 1'b1;
    step(1);
    rst = 1'b0;
    step(8);
    check_val("midrst_resp_b", 32'(resp_seen[1] - snap), 32'd0);
    check_val("midrst_cnt0_b", 32'(c0_b), 32'd0);
    check_val("midrst_cnt0_a", 32'(c0_a), 32'd0);

    // Saturation of the 4-bit counter
    do_reset();
    v1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      d1 = 8'(8'hC0 + i);
      step(1);
    end
    v1 = 1'b0;
    step(8);
    check_val("sat_cnt1_b", 32'(c1_b), 32'd15);
    check_val("sat_cnt1_a", 32'(c1_a), 32'd20);

    check_val("drain_a", sb_q[0].size(), 32'd0);
    check_val("drain_b", sb_q[1].size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
